// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit over a word-organised data memory.
// Loads complete in one cycle with sign/zero extension; byte and halfword
// stores run a two-cycle read-modify-write while holding the pipeline.
//
// Handshake: a request (i_mem_read | i_mem_write, write wins) is taken only on
// a posedge where the unit is IDLE and i_step is high. Completion is reported
// by a one-cycle o_done pulse (with o_misaligned for rejected requests).
// While o_stall is high the upstream register must hold the request steady.
// The current FSM state is visible on o_stall (high exactly in RMW).
module mem_access_unit #(
   parameter int NB           = 32,
   parameter int NB_SIZE_TYPE = 3,
   parameter int NB_ADDR      = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_step,
   input  logic [NB-1:0]           i_alu_result,
   input  logic [NB-1:0]           i_data_b_to_write,
   input  logic                    i_mem_read,
   input  logic                    i_mem_write,
   input  logic                    i_signed,
   input  logic [NB_SIZE_TYPE-1:0] i_word_size,
   input  logic [NB_ADDR-1:0]      i_dbg_addr,
   output logic [NB-1:0]           o_read_data,
   output logic                    o_done,
   output logic                    o_stall,
   output logic                    o_misaligned,
   output logic [NB-1:0]           o_dbg_data
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RMW  = 1'b1;

   localparam logic [NB_SIZE_TYPE-1:0] SZ_BYTE = NB_SIZE_TYPE'(1);
   localparam logic [NB_SIZE_TYPE-1:0] SZ_HALF = NB_SIZE_TYPE'(2);
   localparam logic [NB_SIZE_TYPE-1:0] SZ_WORD = NB_SIZE_TYPE'(4);

   logic [NB-1:0] mem [0:(1<<NB_ADDR)-1];

   logic [0:0]         state;
   logic [NB_ADDR-1:0] idx;
   logic [1:0]         lane;
   logic               req;
   logic               accept;
   logic               is_byte;
   logic               is_half;
   logic               is_word;
   logic               fault;
   logic [NB-1:0]      cur_word;
   logic [NB-1:0]      load_ext;

   // captured context of a sub-word store between its two edges
   logic [NB_ADDR-1:0] rmw_idx;
   logic [NB-1:0]      rmw_word;
   logic [15:0]        rmw_data;
   logic [1:0]         rmw_lane;
   logic               rmw_half;
   logic [NB-1:0]      rmw_merged;

   logic               mem_we;
   logic [NB_ADDR-1:0] mem_widx;
   logic [NB-1:0]      mem_wdata;

   logic unused_addr_bits;
   assign unused_addr_bits = ^i_alu_result[NB-1:NB_ADDR+2];

   assign idx      = i_alu_result[NB_ADDR+1:2];
   assign lane     = i_alu_result[1:0];
   assign req      = i_mem_read | i_mem_write;
   assign accept   = (state == ST_IDLE) && i_step && req;
   assign is_byte  = (i_word_size == SZ_BYTE);
   assign is_half  = (i_word_size == SZ_HALF);
   assign is_word  = (i_word_size == SZ_WORD);
   assign fault    = !(is_byte || is_half || is_word) ||
                     (is_half && lane[0]) ||
                     (is_word && (lane != 2'b00));
   assign cur_word = mem[idx];
   assign o_stall  = (state == ST_RMW);
   assign o_dbg_data = mem[i_dbg_addr];

   // select and extend the addressed lane(s) of the current word for a load
   always_comb begin
      logic [NB-1:0] shifted;
      shifted  = cur_word >> {lane, 3'b000};
      load_ext = cur_word;
      if (is_byte) begin
         load_ext = {{(NB-8){i_signed & shifted[7]}}, shifted[7:0]};
      end else if (is_half) begin
         load_ext = {{(NB-16){i_signed & shifted[15]}}, shifted[15:0]};
      end
   end

   // replace only the targeted lanes of the captured word
   always_comb begin
      rmw_merged = rmw_word;
      if (rmw_half) begin
         if (rmw_lane[1]) rmw_merged[31:16] = rmw_data;
         else             rmw_merged[15:0]  = rmw_data;
      end else begin
         case (rmw_lane)
            2'd0:    rmw_merged[7:0]   = rmw_data[7:0];
            2'd1:    rmw_merged[15:8]  = rmw_data[7:0];
            2'd2:    rmw_merged[23:16] = rmw_data[7:0];
            default: rmw_merged[31:24] = rmw_data[7:0];
         endcase
      end
   end

   // single memory write port: RMW completion or an aligned word store
   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = idx;
      mem_wdata = i_data_b_to_write;
      if ((state == ST_RMW) && i_step) begin
         mem_we    = 1'b1;
         mem_widx  = rmw_idx;
         mem_wdata = rmw_merged;
      end else if (accept && i_mem_write && !fault && is_word) begin
         mem_we = 1'b1;
      end
   end

   // memory array is never cleared; writes are suppressed while in reset
   always_ff @(posedge i_clk) begin
      if (mem_we && i_reset_n) begin
         mem[mem_widx] <= mem_wdata;
      end
   end

   // request sequencing, completion pulses and registered load result
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= ST_IDLE;
         o_read_data  <= '0;
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         rmw_idx      <= '0;
         rmw_word     <= '0;
         rmw_data     <= '0;
         rmw_lane     <= '0;
         rmw_half     <= 1'b0;
      end else begin
         o_done       <= 1'b0;
         o_misaligned <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (fault) begin
                     o_read_data  <= '0;
                     o_done       <= 1'b1;
                     o_misaligned <= 1'b1;
                  end else if (i_mem_write) begin
                     if (is_word) begin
                        o_done <= 1'b1;
                     end else begin
                        rmw_idx  <= idx;
                        rmw_word <= cur_word;
                        rmw_data <= i_data_b_to_write[15:0];
                        rmw_lane <= lane;
                        rmw_half <= is_half;
                        state    <= ST_RMW;
                     end
                  end else begin
                     o_read_data <= load_ext;
                     o_done      <= 1'b1;
                  end
               end
            end
            ST_RMW: begin
               if (i_step) begin
                  state  <= ST_IDLE;
                  o_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, hand-written multi-cycle
// sequences and randomized operations against a byte-level memory model.
module tb_mem_access_unit;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_step = 1'b1;
   logic [31:0] i_alu_result = '0;
   logic [31:0] i_data_b_to_write = '0;
   logic        i_mem_read = 1'b0;
   logic        i_mem_write = 1'b0;
   logic        i_signed = 1'b0;
   logic [2:0]  i_word_size = 3'b100;
   logic [7:0]  i_dbg_addr = '0;
   logic [31:0] o_read_data;
   logic        o_done;
   logic        o_stall;
   logic        o_misaligned;
   logic [31:0] o_dbg_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl [0:255];
   logic [31:0] exp_last;

   mem_access_unit dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_step(i_step),
      .i_alu_result(i_alu_result), .i_data_b_to_write(i_data_b_to_write),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_signed(i_signed),
      .i_word_size(i_word_size), .i_dbg_addr(i_dbg_addr),
      .o_read_data(o_read_data), .o_done(o_done), .o_stall(o_stall),
      .o_misaligned(o_misaligned), .o_dbg_data(o_dbg_data)
   );

   // clock
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        sgn;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rdata;
      logic        exp_mis;
      int          exp_stall;
      logic [7:0]  dbg_idx;
      logic [31:0] exp_dbg;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(logic rd, logic wr, logic sgn, logic [2:0] size,
                               logic [31:0] addr, logic [31:0] data,
                               logic [31:0] exp_rdata, logic exp_mis,
                               int exp_stall, logic [7:0] dbg_idx,
                               logic [31:0] exp_dbg);
      vec_t v;
      v.rd = rd; v.wr = wr; v.sgn = sgn; v.size = size; v.addr = addr;
      v.data = data; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
      v.exp_stall = exp_stall; v.dbg_idx = dbg_idx; v.exp_dbg = exp_dbg;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // apply one request, wait (bounded) for o_done, then drop the request
   task automatic run_op(input logic rd, input logic wr, input logic sgn,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [7:0] dbg,
                         output logic done, output logic mis,
                         output logic [31:0] rdata, output int stalls);
      i_mem_read = rd; i_mem_write = wr; i_signed = sgn; i_word_size = size;
      i_alu_result = addr; i_data_b_to_write = data; i_dbg_addr = dbg;
      done = 1'b0; mis = 1'b0; rdata = '0; stalls = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge i_clk); #1;
         if (o_done) begin
            done = 1'b1; mis = o_misaligned; rdata = o_read_data;
            break;
         end
         if (o_stall) stalls++;
      end
      i_mem_read = 1'b0; i_mem_write = 1'b0;
   endtask

   // reference model: byte-lane arithmetic on a word array
   task automatic ref_op(input logic rd, input logic wr, input logic sgn,
                         input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] data, output logic mis, output int stall);
      int nbytes;
      logic [7:0] idx;
      int lane;
      logic [31:0] v, mask;
      nbytes = (size == 3'd1) ? 1 : (size == 3'd2) ? 2 : (size == 3'd4) ? 4 : 0;
      idx = addr[9:2];
      lane = int'(addr[1:0]);
      mis = 1'b0; stall = 0;
      if (!rd && !wr) return;
      if (nbytes == 0 || (addr % nbytes) != 0) begin
         mis = 1'b1;
         exp_last = 32'h0;
      end else if (wr) begin
         for (int k = 0; k < nbytes; k++) mdl[idx][8*(lane+k) +: 8] = data[8*k +: 8];
         stall = (nbytes < 4) ? 1 : 0;
      end else begin
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8*nbytes)) - 32'h1;
         v = (mdl[idx] >> (8*lane)) & mask;
         if (sgn && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
         exp_last = v;
      end
   endtask

   initial begin
      logic        done, mis;
      logic [31:0] rdata;
      int          stalls;
      logic        emis;
      int          estall;

      // reset block
      i_reset_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("reset_rdata", o_read_data, 32'h0);
      chk("reset_done", {31'h0, o_done}, 32'h0);
      chk("reset_stall", {31'h0, o_stall}, 32'h0);
      chk("reset_mis", {31'h0, o_misaligned}, 32'h0);
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;

      // directed table
      vecs[0]  = mk(0,1,0,3'b100,32'h10,32'hDEADBEEF,32'h0,0,0,8'd4,32'hDEADBEEF);
      vecs[1]  = mk(1,0,0,3'b100,32'h10,32'h0,32'hDEADBEEF,0,0,8'd4,32'hDEADBEEF);
      vecs[2]  = mk(0,1,0,3'b001,32'h11,32'h123456AB,32'hDEADBEEF,0,1,8'd4,32'hDEADABEF);
      vecs[3]  = mk(1,0,1,3'b001,32'h11,32'h0,32'hFFFFFFAB,0,0,8'd4,32'hDEADABEF);
      vecs[4]  = mk(1,0,0,3'b001,32'h11,32'h0,32'h000000AB,0,0,8'd4,32'hDEADABEF);
      vecs[5]  = mk(0,1,0,3'b010,32'h12,32'h00008001,32'h000000AB,0,1,8'd4,32'h8001ABEF);
      vecs[6]  = mk(1,0,1,3'b010,32'h12,32'h0,32'hFFFF8001,0,0,8'd4,32'h8001ABEF);
      vecs[7]  = mk(1,0,0,3'b010,32'h10,32'h0,32'h0000ABEF,0,0,8'd4,32'h8001ABEF);
      vecs[8]  = mk(1,0,0,3'b100,32'h13,32'h0,32'h0,1,0,8'd4,32'h8001ABEF);
      vecs[9]  = mk(0,1,0,3'b010,32'h11,32'h5555,32'h0,1,0,8'd4,32'h8001ABEF);
      vecs[10] = mk(1,0,0,3'b011,32'h10,32'h0,32'h0,1,0,8'd4,32'h8001ABEF);
      vecs[11] = mk(1,1,0,3'b100,32'h20,32'h12345678,32'h0,0,0,8'd8,32'h12345678);
      vecs[12] = mk(1,0,0,3'b100,32'h420,32'h0,32'h12345678,0,0,8'd8,32'h12345678);

      foreach (vecs[i]) begin
         run_op(vecs[i].rd, vecs[i].wr, vecs[i].sgn, vecs[i].size, vecs[i].addr,
                vecs[i].data, vecs[i].dbg_idx, done, mis, rdata, stalls);
         chk($sformatf("vec%0d_done", i), {31'h0, done}, 32'h1);
         chk($sformatf("vec%0d_mis", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
         chk($sformatf("vec%0d_stall", i), stalls, vecs[i].exp_stall);
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_dbg", i), o_dbg_data, vecs[i].exp_dbg);
      end

      // RMW held by i_step=0: byte 0xCD into lane 0 of idx 8
      i_mem_write = 1'b1; i_word_size = 3'b001; i_alu_result = 32'h20;
      i_data_b_to_write = 32'h000000CD; i_dbg_addr = 8'd8;
      @(posedge i_clk); #1;
      chk("hold_stall_e0", {31'h0, o_stall}, 32'h1);
      i_step = 1'b0;
      repeat (3) begin
         @(posedge i_clk); #1;
         chk("hold_stall", {31'h0, o_stall}, 32'h1);
         chk("hold_done", {31'h0, o_done}, 32'h0);
         chk("hold_nowrite", o_dbg_data, 32'h12345678);
      end
      i_step = 1'b1;
      @(posedge i_clk); #1;
      chk("hold_done_e1", {31'h0, o_done}, 32'h1);
      chk("hold_stall_e1", {31'h0, o_stall}, 32'h0);
      chk("hold_written", o_dbg_data, 32'h123456CD);
      i_mem_write = 1'b0;

      // async reset in the middle of an RMW: byte 0xEE to lane 1 is abandoned
      @(posedge i_clk); #1;
      i_mem_write = 1'b1; i_alu_result = 32'h21; i_data_b_to_write = 32'hEE;
      @(posedge i_clk); #1;
      chk("rst_rmw_stall", {31'h0, o_stall}, 32'h1);
      #2 i_reset_n = 1'b0;
      #1;
      chk("rst_async_stall", {31'h0, o_stall}, 32'h0);
      chk("rst_async_done", {31'h0, o_done}, 32'h0);
      chk("rst_async_rdata", o_read_data, 32'h0);
      @(posedge i_clk); #1;
      chk("rst_word_kept", o_dbg_data, 32'h123456CD);
      i_mem_write = 1'b0;
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      chk("rst_word_kept2", o_dbg_data, 32'h123456CD);

      // randomized: seed words 0..15, then mixed operations vs model
      exp_last = 32'h0;
      for (int w = 0; w < 16; w++) begin
         logic [31:0] d;
         d = $urandom();
         ref_op(1'b0, 1'b1, 1'b0, 3'b100, 32'(w*4), d, emis, estall);
         run_op(1'b0, 1'b1, 1'b0, 3'b100, 32'(w*4), d, 8'(w), done, mis, rdata, stalls);
         chk("seed_done", {31'h0, done}, 32'h1);
      end
      for (int t = 0; t < 200; t++) begin
         logic rd, wr, sgn;
         logic [2:0] size;
         logic [31:0] addr, data;
         int sel, k;
         logic [7:0] widx;
         widx = 8'($urandom_range(0, 15));
         addr = ($urandom() & 32'hFFFF_FC00) | {22'h0, widx, 2'($urandom_range(0, 3))};
         sel = $urandom_range(0, 7);
         size = (sel < 2) ? 3'b001 : (sel < 4) ? 3'b010 : (sel < 6) ? 3'b100 :
                (sel == 6) ? 3'b011 : 3'b000;
         k = $urandom_range(1, 3);
         wr = k[1]; rd = k[0];
         sgn = 1'($urandom_range(0, 1));
         data = $urandom();
         ref_op(rd, wr, sgn, size, addr, data, emis, estall);
         run_op(rd, wr, sgn, size, addr, data, widx, done, mis, rdata, stalls);
         chk($sformatf("rnd%0d_done", t), {31'h0, done}, 32'h1);
         chk($sformatf("rnd%0d_mis", t), {31'h0, mis}, {31'h0, emis});
         chk($sformatf("rnd%0d_stall", t), stalls, estall);
         chk($sformatf("rnd%0d_rdata", t), rdata, exp_last);
         chk($sformatf("rnd%0d_dbg", t), o_dbg_data, mdl[widx]);
      end

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs: the alu_result address, store data, mem_read/mem_write, word_size and signed controls.
- Performs byte, halfword and word loads/stores on an internal word-organised data memory.
- Returns sign- or zero-extended load data toward MEM/WB.
- Stalls the pipeline for the two-cycle read-modify-write needed by sub-word stores.
- Has a combinational debug read port for the debug unit.

Parameters:
NB, 32, data/address width
NB_SIZE_TYPE, 3, width of word_size code
NB_ADDR, 8, word-index width; memory depth = 2**NB_ADDR words

Ports:
i_clk  in  1  clock, posedge active
i_reset_n  in  1  asynchronous active-low reset
i_step  in  1  advance enable; when low, no request accepted and no state change
i_alu_result  in  NB  byte address
i_data_b_to_write  in  NB  store data (low bits used for sub-word)
i_mem_read  in  1  load request
i_mem_write  in  1  store request
i_signed  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
i_word_size  in  NB_SIZE_TYPE  3'b001 byte, 3'b010 half, 3'b100 word
i_dbg_addr  in  NB_ADDR  debug word index
o_read_data  out  NB  registered load result
o_done  out  1  one-cycle pulse: request finished
o_stall  out  1  hold upstream pipeline registers
o_misaligned  out  1  one-cycle pulse with o_done: request rejected
o_dbg_data  out  NB  combinational mem[i_dbg_addr]

Behaviour:
- Reset (async, i_reset_n=0):
  - state=IDLE.
  - o_read_data=0, o_done=0, o_stall=0, o_misaligned=0.
  - Memory array is not cleared; an in-flight RMW is abandoned with no write.
- Addressing:
  - word index = i_alu_result[NB_ADDR+1:2]; upper bits ignored, so addresses wrap modulo depth.
  - Lane = i_alu_result[1:0], little-endian: lane 0 = bits 7:0.
- Request present = i_mem_read | i_mem_write. If both are high, the write wins and the read is ignored.
- Acceptance: a request is accepted only at a posedge with state=IDLE and i_step=1. Unacceptable cases are listed under Errors.
- States: IDLE, RMW.
- Word store, at accept edge E0:
  - mem[idx] <= data.
  - o_done=1 for the cycle after E0; state stays IDLE.
- Load, at E0:
  - o_read_data <= word, or the selected byte/half extended per i_signed.
  - o_done=1 for the cycle after E0 (latency 1).
- Byte/half store, two steps:
  - E0: capture mem[idx], data, lane and size; state -> RMW.
  - E1 (i_step=1): mem[idx] <= merged word (only the targeted lanes replaced); o_done=1 after E1; state -> IDLE.
  - If i_step=0 in RMW: hold state, no write.
- o_stall = (state==RMW), purely registered. The pipeline register therefore holds the request through E1 and no RMW request is accepted twice.
- Errors, handled at accept:
  - Misalignment = half with addr[0]=1, or word with addr[1:0]!=0.
  - Invalid size code = any word_size other than 001/010/100.
  - On either: no memory change, o_read_data <= 0, o_done=1 and o_misaligned=1 for one cycle.
- With no request present: o_done=0 and o_read_data holds its last value.
- o_dbg_data reads the array combinationally and reflects writes after the writing edge.

Test Plan:
1. Reset then word store 0xDEADBEEF @0x10; next cycle word load @0x10 -> o_done pulse, o_read_data=0xDEADBEEF, o_stall never high.
2. Byte store 0xAB @0x11 over 0xDEADBEEF -> o_stall high exactly one cycle, o_done after E1, o_dbg_data(idx 4)=0xDEADABEF; signed byte load @0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
3. Half store 0x8001 @0x12 -> word 0x8001ABEF; signed half load @0x12 -> 0xFFFF8001; unsigned half load @0x10 -> 0x0000ABEF.
4. Word load @0x13 and half store @0x11 -> o_misaligned+o_done pulse, o_read_data=0, memory unchanged; word_size=3'b011 -> same fault response.
5. i_step=0 during RMW -> state held, o_stall stays 1, no write until i_step=1; i_reset_n low mid-RMW -> outputs 0 immediately (async), word unchanged.
6. mem_read and mem_write both high, word @0x20 data 0x12345678 -> store performed, o_dbg_data(idx 8)=0x12345678; address 0x400+0x20 with NB_ADDR=8 wraps to idx 8.
